// File: rtl/tulul_pkg.sv
// TileLink-UL shared types for the device adapter.
// Provides bus widths, A/D opcodes, the host-to-device and device-to-host
// channel structs, and the tracking-entry struct that the adapter keeps
// for every accepted A request until its D response is delivered.
package tulul_pkg;

  localparam int TL_AW  = 32;
  localparam int TL_DW  = 32;
  localparam int TL_DBW = TL_DW / 8;
  localparam int TL_AIW = 8;
  localparam int TL_SZW = 2;
  localparam int TL_DIW = 1;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  // Opcode fields are plain vectors so that out-of-range opcodes from the
  // host can be represented and rejected.
  typedef struct packed {
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [TL_SZW-1:0] a_size;
    logic [TL_AIW-1:0] a_source;
    logic [TL_AW-1:0]  a_address;
    logic [TL_DBW-1:0] a_mask;
    logic [TL_DW-1:0]  a_data;
    logic              d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [2:0]        d_param;
    logic [TL_SZW-1:0] d_size;
    logic [TL_AIW-1:0] d_source;
    logic [TL_DIW-1:0] d_sink;
    logic [TL_DW-1:0]  d_data;
    logic              d_error;
    logic              a_ready;
  } tl_d2h_t;

  // One entry per accepted A request; err marks requests that were
  // rejected locally and never reached the device.
  typedef struct packed {
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    logic              is_read;
    logic              err;
  } tl_trk_t;

endpackage

// File: rtl/tlul_fifo_sync.sv
// Synchronous FIFO with valid/ready on both sides.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (empties FIFO)
//   wvalid_i/wready_o    write side; wready_o is low whenever the FIFO is
//                        full, regardless of a same-cycle read
//   wdata_i              write data
//   rvalid_o/rready_i    read side; rvalid_o high while not empty
//   rdata_o              head entry
// Handshake: a transfer happens on a side exactly in a cycle where both its
// valid and ready are high; valid never depends on ready.
module tlul_fifo_sync #(
  parameter int Width = 8,
  parameter int Depth = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  // Pointers wrap modulo Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign wready_o = (cnt_q != CntW'(Depth));
  assign rvalid_o = (cnt_q != '0);
  assign push     = wvalid_i & wready_o;
  assign pop      = rready_i & rvalid_o;
  assign rdata_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (push) wptr_d = ptr_inc(wptr_q);
    if (pop)  rptr_d = ptr_inc(rptr_q);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/tlul_device_adapter.sv
// TileLink-UL device adapter: turns TL-UL A requests into a simple
// req/gnt/rvalid device interface and returns D responses in order.
// Ports:
//   clock, reset       clock, asynchronous active-low reset
//   tl_d_c_a           A channel from the host plus d_ready
//   tl_d_c_d           D channel to the host plus a_ready
//   req_o, we_o        device request / write enable
//   addr_o, wdata_o,   address, write data and byte enables, passed
//   be_o               straight through from the A channel
//   gnt_i              device accepts req_o this cycle
//   rvalid_i, rdata_i, one in-order response per granted request
//   rerror_i
// Handshakes: A transfers when a_valid & a_ready, D transfers when
// d_valid & d_ready, device request transfers when req_o & gnt_i.
// a_ready never depends on d_ready.
module tlul_device_adapter
  import tulul_pkg::*;
#(
  parameter int unsigned Outstanding = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  tl_h2d_t           tl_d_c_a,
  output tl_d2h_t           tl_d_c_d,
  output logic              req_o,
  output logic              we_o,
  output logic [TL_AW-1:0]  addr_o,
  output logic [TL_DW-1:0]  wdata_o,
  output logic [TL_DBW-1:0] be_o,
  input  logic              gnt_i,
  input  logic              rvalid_i,
  input  logic [TL_DW-1:0]  rdata_i,
  input  logic              rerror_i
);

  logic    is_get, is_pfd, is_ppd, legal;
  logic    a_ready, a_hs;
  logic    trk_wready, trk_rvalid, trk_pop;
  tl_trk_t trk_wdata, trk_head;
  logic    rsp_wready, rsp_rvalid, rsp_push, rsp_pop;
  logic [TL_DW:0] rsp_wdata, rsp_head;
  logic    d_valid, d_hs, d_error;

  always_comb begin
    is_get = (tl_d_c_a.a_opcode == Get);
    is_pfd = (tl_d_c_a.a_opcode == PutFullData);
    is_ppd = (tl_d_c_a.a_opcode == PutPartialData);
    legal  = (is_get | is_pfd | is_ppd)
           & (tl_d_c_a.a_param == 3'd0)
           & (tl_d_c_a.a_size == TL_SZW'(2))
           & (tl_d_c_a.a_address[1:0] == 2'b00)
           & !((is_get | is_pfd) & (tl_d_c_a.a_mask != '1))
           & !(is_ppd & (tl_d_c_a.a_mask == '0));
  end

  // Illegal requests are accepted locally (no grant needed) and answered
  // with an error; legal ones are accepted only when the device grants.
  // Both are held off while reset is asserted.
  assign a_ready = reset & trk_wready & (gnt_i | ~legal);
  assign req_o   = reset & tl_d_c_a.a_valid & legal & trk_wready;
  assign we_o    = is_pfd | is_ppd;
  assign addr_o  = tl_d_c_a.a_address;
  assign wdata_o = tl_d_c_a.a_data;
  assign be_o    = tl_d_c_a.a_mask;
  assign a_hs    = tl_d_c_a.a_valid & a_ready;

  always_comb begin
    trk_wdata         = '0;
    trk_wdata.source  = tl_d_c_a.a_source;
    trk_wdata.size    = tl_d_c_a.a_size;
    trk_wdata.is_read = is_get;
    trk_wdata.err     = ~legal;
  end

  tlul_fifo_sync #(
    .Width ($bits(tl_trk_t)),
    .Depth (int'(Outstanding))
  ) u_trk_fifo (
    .clk_i    (clock),
    .rst_ni   (reset),
    .wvalid_i (a_hs),
    .wready_o (trk_wready),
    .wdata_i  (trk_wdata),
    .rvalid_o (trk_rvalid),
    .rready_i (trk_pop),
    .rdata_o  (trk_head)
  );

  // A response with nothing tracked can only be a leftover from before a
  // reset, so it is dropped. Depth equals Outstanding, so rsp_wready only
  // matters for such leftovers.
  assign rsp_wdata = {rdata_i, rerror_i};
  assign rsp_push  = rvalid_i & trk_rvalid & rsp_wready;

  tlul_fifo_sync #(
    .Width (TL_DW + 1),
    .Depth (int'(Outstanding))
  ) u_rsp_fifo (
    .clk_i    (clock),
    .rst_ni   (reset),
    .wvalid_i (rsp_push),
    .wready_o (rsp_wready),
    .wdata_i  (rsp_wdata),
    .rvalid_o (rsp_rvalid),
    .rready_i (rsp_pop),
    .rdata_o  (rsp_head)
  );

  // Locally rejected entries have no device response to wait for.
  assign d_valid = trk_rvalid & (trk_head.err | rsp_rvalid);
  assign d_hs    = d_valid & tl_d_c_a.d_ready;
  assign trk_pop = d_hs;
  assign rsp_pop = d_hs & ~trk_head.err;
  assign d_error = trk_head.err | (~trk_head.err & rsp_head[0]);

  // Fields come only from FIFO heads, which cannot change until the pop,
  // so they hold while the host stalls. They read as zero when idle.
  always_comb begin
    tl_d_c_d         = '0;
    tl_d_c_d.a_ready = a_ready;
    tl_d_c_d.d_valid = d_valid;
    if (d_valid) begin
      tl_d_c_d.d_opcode = trk_head.is_read ? AccessAckData : AccessAck;
      tl_d_c_d.d_source = trk_head.source;
      tl_d_c_d.d_size   = trk_head.size;
      tl_d_c_d.d_error  = d_error;
      tl_d_c_d.d_data   = (trk_head.is_read & ~d_error) ? rsp_head[TL_DW:1] : '0;
    end
  end

endmodule

// File: tb/tb_tlul_device_adapter.sv
module tb_tlul_device_adapter;
  import tulul_pkg::*;

  localparam int NI = 2;  // instance 0: Outstanding=2, instance 1: Outstanding=3

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #10 clock = ~clock;

  tl_h2d_t     a;
  logic        gnt, rvalid, rerror;
  logic [31:0] rdata;

  tl_d2h_t     d     [NI];
  logic        req   [NI];
  logic        we    [NI];
  logic [31:0] addr  [NI];
  logic [31:0] wdata [NI];
  logic [3:0]  be    [NI];

  tlul_device_adapter #(.Outstanding(2)) u_dut2 (
    .clock(clock), .reset(reset), .tl_d_c_a(a), .tl_d_c_d(d[0]),
    .req_o(req[0]), .we_o(we[0]), .addr_o(addr[0]), .wdata_o(wdata[0]), .be_o(be[0]),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .rerror_i(rerror)
  );

  tlul_device_adapter #(.Outstanding(3)) u_dut3 (
    .clock(clock), .reset(reset), .tl_d_c_a(a), .tl_d_c_d(d[1]),
    .req_o(req[1]), .we_o(we[1]), .addr_o(addr[1]), .wdata_o(wdata[1]), .be_o(be[1]),
    .gnt_i(gnt), .rvalid_i(rvalid), .rdata_i(rdata), .rerror_i(rerror)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per instance, a list of accepted requests awaiting
  // their answer and a list of device responses not yet delivered.
  typedef struct {
    logic [7:0] src;
    logic [1:0] size;
    bit         rd;
    bit         err;
  } m_trk_t;

  m_trk_t      mt      [NI][16];
  int          mt_n    [NI];
  logic [31:0] mr_data [NI][16];
  bit          mr_err  [NI][16];
  int          mr_n    [NI];

  function automatic int cap(input int i);
    return (i == 0) ? 2 : 3;
  endfunction

  function automatic bit m_legal();
    bit ok;
    case (a.a_opcode)
      Get, PutFullData: ok = (a.a_mask == 4'hF);
      PutPartialData:   ok = (a.a_mask != 4'h0);
      default:          ok = 1'b0;
    endcase
    return ok && (a.a_param == 0) && (a.a_size == 2) && (a.a_address % 4 == 0);
  endfunction

  function automatic bit m_dvalid(input int i);
    return (mt_n[i] > 0) && (mt[i][0].err || (mr_n[i] > 0));
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NI; i++) begin
        mt_n[i] = 0;
        mr_n[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit lg, ahs, dhs, rpush, herr;
        lg    = m_legal();
        ahs   = a.a_valid && (mt_n[i] < cap(i)) && (gnt || !lg);
        dhs   = m_dvalid(i) && a.d_ready;
        rpush = rvalid && (mt_n[i] > 0) && (mr_n[i] < cap(i));
        if (dhs) begin
          herr = mt[i][0].err;
          for (int k = 1; k < mt_n[i]; k++) mt[i][k-1] = mt[i][k];
          mt_n[i]--;
          if (!herr) begin
            for (int k = 1; k < mr_n[i]; k++) begin
              mr_data[i][k-1] = mr_data[i][k];
              mr_err[i][k-1]  = mr_err[i][k];
            end
            mr_n[i]--;
          end
        end
        if (ahs) begin
          mt[i][mt_n[i]].src  = a.a_source;
          mt[i][mt_n[i]].size = a.a_size;
          mt[i][mt_n[i]].rd   = (a.a_opcode == Get);
          mt[i][mt_n[i]].err  = !lg;
          mt_n[i]++;
        end
        if (rpush) begin
          mr_data[i][mr_n[i]] = rdata;
          mr_err[i][mr_n[i]]  = rerror;
          mr_n[i]++;
        end
      end
    end
  end

  // Compare process: every cycle, mid-cycle, both instances.
  always @(negedge clock) begin
    for (int i = 0; i < NI; i++) begin
      string  t;
      bit     lg, room, dv, err;
      m_trk_t h;
      t = (i == 0) ? "o2" : "o3";
      if (!reset) begin
        check({t, " rst d_valid"}, d[i].d_valid, 0);
        check({t, " rst a_ready"}, d[i].a_ready, 0);
        check({t, " rst req_o"}, req[i], 0);
        check({t, " rst d_data"}, d[i].d_data, 0);
        check({t, " rst d_source"}, d[i].d_source, 0);
        check({t, " rst d_error"}, d[i].d_error, 0);
      end else begin
        lg   = m_legal();
        room = mt_n[i] < cap(i);
        check({t, " req_o"}, req[i], a.a_valid && lg && room);
        check({t, " a_ready"}, d[i].a_ready, room && (gnt || !lg));
        if (a.a_valid && lg && room) begin
          check({t, " we_o"}, we[i], a.a_opcode != Get);
          check({t, " addr_o"}, addr[i], a.a_address);
          check({t, " wdata_o"}, wdata[i], a.a_data);
          check({t, " be_o"}, be[i], a.a_mask);
        end
        dv = m_dvalid(i);
        check({t, " d_valid"}, d[i].d_valid, dv);
        if (dv) begin
          h   = mt[i][0];
          err = h.err ? 1'b1 : mr_err[i][0];
          check({t, " d_opcode"}, d[i].d_opcode, h.rd ? 1 : 0);
          check({t, " d_source"}, d[i].d_source, h.src);
          check({t, " d_size"}, d[i].d_size, h.size);
          check({t, " d_param"}, d[i].d_param, 0);
          check({t, " d_sink"}, d[i].d_sink, 0);
          check({t, " d_error"}, d[i].d_error, err);
          check({t, " d_data"}, d[i].d_data, (h.rd && !err) ? mr_data[i][0] : 32'h0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic put_a(input logic [2:0] op, input logic [31:0] adr, input logic [7:0] src,
                       input logic [3:0] msk, input logic [31:0] dat, input logic [1:0] sz);
    a.a_valid   = 1'b1;
    a.a_opcode  = op;
    a.a_param   = 3'd0;
    a.a_size    = sz;
    a.a_source  = src;
    a.a_address = adr;
    a.a_mask    = msk;
    a.a_data    = dat;
  endtask

  task automatic idle_a();
    a.a_valid = 1'b0;
    gnt       = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [2:0]  il_op   [6] = '{Get, Get, PutFullData, PutPartialData, 3'h2, Get};
  logic [31:0] il_adr  [6] = '{32'h10, 32'h102, 32'h8, 32'hC, 32'h14, 32'h18};
  logic [3:0]  il_msk  [6] = '{4'hF, 4'hF, 4'h7, 4'h0, 4'hF, 4'hF};
  logic [1:0]  il_sz   [6] = '{2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
  logic [2:0]  il_par  [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

  initial begin
    a = '0;
    a.d_ready = 1'b1;
    gnt = 1'b0; rvalid = 1'b0; rerror = 1'b0; rdata = '0;
    repeat (2) @(posedge clock);
    #3;
    check("reset d_valid", d[0].d_valid, 0);
    check("reset a_ready", d[0].a_ready, 0);
    @(posedge clock); #2;
    reset = 1'b1;

    // Get 0x100, source 3, response 2 cycles after grant
    tick(); put_a(Get, 32'h100, 8'd3, 4'hF, 32'h0, 2'd2); gnt = 1'b1; settle();
    check("get req_o", req[0], 1);
    check("get we_o", we[0], 0);
    check("get be_o", be[0], 4'hF);
    tick(); idle_a(); settle();
    check("get d_valid c1", d[0].d_valid, 0);
    tick(); rvalid = 1'b1; rdata = 32'hDEADBEEF; settle();
    check("get d_valid c2", d[0].d_valid, 0);
    tick(); rvalid = 1'b0; settle();
    check("get d_valid c3", d[0].d_valid, 1);
    check("get d_opcode", d[0].d_opcode, AccessAckData);
    check("get d_source", d[0].d_source, 3);
    check("get d_size", d[0].d_size, 2);
    check("get d_data", d[0].d_data, 32'hDEADBEEF);
    check("get d_error", d[0].d_error, 0);
    tick(); settle();
    check("get popped", d[0].d_valid, 0);

    // PutPartialData mask 0x3 to 0x4
    tick(); put_a(PutPartialData, 32'h4, 8'd5, 4'h3, 32'h1234, 2'd2); gnt = 1'b1; settle();
    check("ppd be_o", be[0], 4'h3);
    check("ppd we_o", we[0], 1);
    check("ppd wdata_o", wdata[0], 32'h1234);
    tick(); idle_a(); rvalid = 1'b1; rdata = 32'h0; settle();
    tick(); rvalid = 1'b0; settle();
    check("ppd d_valid", d[0].d_valid, 1);
    check("ppd d_opcode", d[0].d_opcode, AccessAck);
    check("ppd d_error", d[0].d_error, 0);
    check("ppd d_source", d[0].d_source, 5);

    // device-reported error on a Get
    tick(); put_a(Get, 32'h20, 8'd9, 4'hF, 32'h0, 2'd2); gnt = 1'b1;
    tick(); idle_a(); rvalid = 1'b1; rerror = 1'b1; rdata = 32'hFFFF0000;
    tick(); rvalid = 1'b0; rerror = 1'b0; settle();
    check("derr d_error", d[0].d_error, 1);
    check("derr d_data", d[0].d_data, 0);

    // illegal requests: answered locally, never reach the device
    for (int j = 0; j < 6; j++) begin
      tick(); put_a(il_op[j], il_adr[j], 8'(16 + j), il_msk[j], 32'hA5A5A5A5, il_sz[j]);
      a.a_param = il_par[j]; gnt = 1'b0; settle();
      check($sformatf("illegal%0d req_o", j), req[0], 0);
      check($sformatf("illegal%0d a_ready", j), d[0].a_ready, 1);
      tick(); idle_a(); settle();
      check($sformatf("illegal%0d d_valid", j), d[0].d_valid, 1);
      check($sformatf("illegal%0d d_error", j), d[0].d_error, 1);
      check($sformatf("illegal%0d d_data", j), d[0].d_data, 0);
      check($sformatf("illegal%0d d_source", j), d[0].d_source, 16 + j);
    end

    // back-pressure with Outstanding=2
    tick(); a.d_ready = 1'b0; put_a(Get, 32'h200, 8'd0, 4'hF, 32'h0, 2'd2); gnt = 1'b1; settle();
    check("bp a_ready 1st", d[0].a_ready, 1);
    tick(); put_a(Get, 32'h204, 8'd1, 4'hF, 32'h0, 2'd2); rvalid = 1'b1; rdata = 32'hA0; settle();
    check("bp a_ready 2nd", d[0].a_ready, 1);
    tick(); put_a(Get, 32'h208, 8'd2, 4'hF, 32'h0, 2'd2); rdata = 32'hA1; settle();
    check("bp a_ready full", d[0].a_ready, 0);
    check("bp req_o full", req[0], 0);
    tick(); rvalid = 1'b0; settle();
    check("bp hold d_source", d[0].d_source, 0);
    check("bp hold d_data", d[0].d_data, 32'hA0);
    tick(); a.d_ready = 1'b1; settle();
    check("bp pop0 d_source", d[0].d_source, 0);
    check("bp pop0 a_ready", d[0].a_ready, 0);
    tick(); settle();
    check("bp pop1 a_ready", d[0].a_ready, 1);
    check("bp pop1 d_source", d[0].d_source, 1);
    check("bp pop1 d_data", d[0].d_data, 32'hA1);
    tick(); idle_a(); rvalid = 1'b1; rdata = 32'hA2;
    tick(); rvalid = 1'b0; settle();
    check("bp third d_source", d[0].d_source, 2);

    // reset with requests outstanding
    tick(); a.d_ready = 1'b0; put_a(Get, 32'h300, 8'd6, 4'hF, 32'h0, 2'd2); gnt = 1'b1;
    tick(); put_a(Get, 32'h304, 8'd7, 4'hF, 32'h0, 2'd2); rvalid = 1'b1; rdata = 32'h11111111;
    tick(); idle_a(); rvalid = 1'b0; settle();
    check("prerst d_valid", d[0].d_valid, 1);
    #2; reset = 1'b0; #1;
    check("rst now d_valid o2", d[0].d_valid, 0);
    check("rst now d_valid o3", d[1].d_valid, 0);
    tick(); tick(); #1; reset = 1'b1; a.d_ready = 1'b1;
    tick(); rvalid = 1'b1; rdata = 32'hBAD0BAD0; settle();
    check("stale d_valid c0", d[0].d_valid, 0);
    tick(); rvalid = 1'b0; settle();
    check("stale d_valid o2", d[0].d_valid, 0);
    check("stale d_valid o3", d[1].d_valid, 0);

    // streaming Gets on the Outstanding=3 instance
    for (int c = 0; c < 9; c++) begin
      tick();
      if (c < 6) begin
        put_a(Get, 32'h400 + 32'(4 * c), 8'(c), 4'hF, 32'h0, 2'd2); gnt = 1'b1;
      end else begin
        idle_a();
      end
      rvalid = (c >= 1) && (c <= 6);
      rdata  = 32'hC0DE0000 + 32'(c - 1);
      settle();
      if (c < 6) check($sformatf("stream a_ready c%0d", c), d[1].a_ready, 1);
      if ((c >= 2) && (c <= 7)) begin
        check($sformatf("stream d_valid c%0d", c), d[1].d_valid, 1);
        check($sformatf("stream d_source c%0d", c), d[1].d_source, c - 2);
        check($sformatf("stream d_data c%0d", c), d[1].d_data, 32'hC0DE0000 + 32'(c - 2));
      end
    end
    tick(); idle_a(); rvalid = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
